// File: rtl/game_sequencer.sv
// Red-Light-Green-Light game controller: screen state, light phase timer,
// movement-violation detection and life tracking.
module game_sequencer #(
    parameter logic [31:0] GREEN_CYCLES = 32'd150_000_000,
    parameter logic [31:0] RED_CYCLES   = 32'd100_000_000,
    parameter logic [31:0] GRACE_CYCLES = 32'd25_000_000,
    parameter logic [1:0]  LIVES        = 2'd3
) (
    input  logic       clk_d,
    input  logic       reset,
    input  logic       start_key,
    input  logic       move,
    input  logic       reached_finish,
    output logic [1:0] state,
    output logic       display_red,
    output logic       display_green,
    output logic [1:0] hearts,
    output logic       hit
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_GAME  = 2'b01,
        ST_WON   = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t      state_r, state_nxt;
    logic        red_r, red_nxt;
    logic        green_r, green_nxt;
    logic [1:0]  hearts_r, hearts_nxt;
    logic        hit_r, hit_nxt;
    logic [31:0] count_r, count_nxt;
    logic        hit_flag_r, hit_flag_nxt;
    logic        key_prev;
    logic        press;
    logic        violation;
    logic        game_lost;

    assign press     = start_key & ~key_prev;
    // hit_flag limits the penalty to one life per red phase
    assign violation = (state_r == ST_GAME) && red_r && (count_r >= GRACE_CYCLES)
                       && move && !hit_flag_r;
    assign game_lost = violation && (hearts_r == 2'd1);

    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            state_r    <= ST_START;
            red_r      <= 1'b0;
            green_r    <= 1'b0;
            hearts_r   <= 2'd0;
            hit_r      <= 1'b0;
            count_r    <= 32'd0;
            hit_flag_r <= 1'b0;
            key_prev   <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            red_r      <= red_nxt;
            green_r    <= green_nxt;
            hearts_r   <= hearts_nxt;
            hit_r      <= hit_nxt;
            count_r    <= count_nxt;
            hit_flag_r <= hit_flag_nxt;
            key_prev   <= start_key;
        end
    end

    always_comb begin
        state_nxt    = state_r;
        red_nxt      = red_r;
        green_nxt    = green_r;
        hearts_nxt   = hearts_r;
        hit_nxt      = 1'b0;
        count_nxt    = count_r;
        hit_flag_nxt = hit_flag_r;

        case (state_r)
            ST_START: begin
                red_nxt    = 1'b0;
                green_nxt  = 1'b0;
                hearts_nxt = 2'd0;
                if (press) begin
                    state_nxt    = ST_GAME;
                    hearts_nxt   = LIVES;
                    green_nxt    = 1'b1;
                    count_nxt    = 32'd0;
                    hit_flag_nxt = 1'b0;
                end
            end

            ST_GAME: begin
                count_nxt = count_r + 32'd1;
                if (green_r && (count_r == GREEN_CYCLES - 32'd1)) begin
                    red_nxt      = 1'b1;
                    green_nxt    = 1'b0;
                    count_nxt    = 32'd0;
                    hit_flag_nxt = 1'b0;
                end else if (red_r && (count_r == RED_CYCLES - 32'd1)) begin
                    red_nxt   = 1'b0;
                    green_nxt = 1'b1;
                    count_nxt = 32'd0;
                end

                if (violation) begin
                    hearts_nxt   = hearts_r - 2'd1;
                    hit_nxt      = 1'b1;
                    hit_flag_nxt = 1'b1;
                end

                // Losing the last life outranks reaching the finish on the same edge
                if (game_lost || reached_finish) begin
                    state_nxt = game_lost ? ST_OVER : ST_WON;
                    red_nxt   = 1'b0;
                    green_nxt = 1'b0;
                    count_nxt = count_r;
                end
            end

            ST_WON, ST_OVER: begin
                if (press) begin
                    state_nxt  = ST_START;
                    hearts_nxt = 2'd0;
                end
            end

            default: state_nxt = ST_START;
        endcase
    end

    assign state         = state_r;
    assign display_red   = red_r;
    assign display_green = green_r;
    assign hearts        = hearts_r;
    assign hit           = hit_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed game scenarios plus random play,
// checked every cycle against a time-in-game reference model.
module tb_game_sequencer;

    localparam int G  = 8;
    localparam int R  = 6;
    localparam int GR = 2;
    localparam int L  = 3;
    localparam int P  = G + R;

    logic       clk_d = 1'b0;
    logic       reset;
    logic       start_key;
    logic       move;
    logic       reached_finish;
    logic [1:0] state;
    logic       display_red;
    logic       display_green;
    logic [1:0] hearts;
    logic       hit;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=START 1=GAME 2=WON 3=OVER; t counts cycles since game entry
    int m_mode, m_hearts, m_t, m_lost;
    bit m_hit, m_prev;

    always #5 clk_d = ~clk_d;

    game_sequencer #(
        .GREEN_CYCLES(32'd8),
        .RED_CYCLES  (32'd6),
        .GRACE_CYCLES(32'd2),
        .LIVES       (2'd3)
    ) dut (
        .clk_d         (clk_d),
        .reset         (reset),
        .start_key     (start_key),
        .move          (move),
        .reached_finish(reached_finish),
        .state         (state),
        .display_red   (display_red),
        .display_green (display_green),
        .hearts        (hearts),
        .hit           (hit)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        m_mode   = 0;
        m_hearts = 0;
        m_t      = 0;
        m_lost   = -1;
        m_hit    = 0;
        m_prev   = 0;
    endtask

    task automatic modelStep();
        bit press;
        bit viol;
        press  = start_key && !m_prev;
        m_prev = start_key;
        m_hit  = 0;
        case (m_mode)
            0: if (press) begin
                m_mode = 1; m_hearts = L; m_t = 0; m_lost = -1;
            end
            1: begin
                viol = ((m_t % P) >= G + GR) && move && (m_lost != m_t / P);
                if (viol) begin
                    m_hearts--; m_hit = 1; m_lost = m_t / P;
                end
                if (viol && m_hearts == 0) m_mode = 3;
                else if (reached_finish)   m_mode = 2;
                else                       m_t++;
            end
            default: if (press) begin
                m_mode = 0; m_hearts = 0;
            end
        endcase
    endtask

    task automatic checkAll();
        bit green;
        green = (m_mode == 1) && ((m_t % P) < G);
        checkOutput("state",  32'(state),         32'(m_mode));
        checkOutput("green",  32'(display_green), 32'(green));
        checkOutput("red",    32'(display_red),   32'((m_mode == 1) && !green));
        checkOutput("hearts", 32'(hearts),        32'(m_hearts));
        checkOutput("hit",    32'(hit),           32'(m_hit));
    endtask

    task automatic tick();
        @(posedge clk_d);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input bit k, input bit m, input bit f);
        start_key      = k;
        move           = m;
        reached_finish = f;
        tick();
    endtask

    // Idle until the red phase has just begun (red counter at 0)
    task automatic waitRed();
        for (int i = 0; i < 2 * P && !(m_mode == 1 && (m_t % P) == G); i++)
            applyStimulus(0, 0, 0);
        checkOutput("reachRed", 32'(m_mode == 1 && (m_t % P) == G), 32'd1);
    endtask

    task automatic loseOneLife();
        waitRed();
        for (int i = 0; i < R; i++) applyStimulus(0, 1, 0);
    endtask

    task automatic startGame();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 3 && m_mode != 1; i++) begin
            applyStimulus(1, 0, 0);
            applyStimulus(0, 0, 0);
        end
        checkOutput("inGame", 32'(state), 32'd1);
    endtask

    initial begin
        modelReset();
        reset = 1'b1; start_key = 0; move = 0; reached_finish = 0;
        repeat (3) @(posedge clk_d);
        #1;
        checkAll();
        @(negedge clk_d);
        reset = 1'b0;

        // Start and hold the key: exactly one press
        applyStimulus(1, 0, 0);
        checkOutput("startGame", 32'(state), 32'd1);
        checkOutput("startHearts", 32'(hearts), 32'd3);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
        for (int i = 0; i < 2 * P; i++) applyStimulus(0, 0, 0);

        // Grace window then a single hit; movement in green is free
        loseOneLife();
        for (int i = 0; i < G; i++) applyStimulus(0, 1, 0);
        checkOutput("oneHit", 32'(hearts), 32'd2);

        // Game over, then back to START
        for (int i = 0; i < 3 * P && m_mode == 1; i++) applyStimulus(0, 1, 0);
        checkOutput("over", 32'(state), 32'd3);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("overToStart", 32'(state), 32'd0);

        // Win in green with two hearts
        startGame();
        loseOneLife();
        applyStimulus(0, 0, 1);
        checkOutput("won", 32'(state), 32'd2);
        checkOutput("wonHearts", 32'(hearts), 32'd2);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);

        // Finish coincides with the last-life hit: OVER wins
        startGame();
        loseOneLife();
        loseOneLife();
        for (int i = 0; i < 2 * P && m_mode == 1; i++)
            applyStimulus(0, 1, (m_t % P) == G + GR);
        checkOutput("tieState", 32'(state), 32'd3);
        applyStimulus(1, 0, 0);

        // Asynchronous reset while hit is high
        startGame();
        for (int i = 0; i < 2 * P && !m_hit; i++) applyStimulus(0, 1, 0);
        checkOutput("hitSeen", 32'(hit), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk_d);
        reset = 1'b0;

        // Random play
        for (int i = 0; i < 3000; i++)
            applyStimulus(($urandom % 12) == 0, ($urandom % 3) == 0, ($urandom % 60) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central controller for the Red-Light-Green-Light game. It owns the screen state (start / game / won / over), alternates the red and green lights on a fixed cycle, samples player movement against the light, and tracks remaining lives. Its outputs drive the pixel generator's screen-select, light and heart rendering. Its inputs come from the keyboard decoder and the player/finish collision logic.

Parameters:
GREEN_CYCLES, 32'd150_000_000, clk_d cycles the green light is shown per phase (≥2).
RED_CYCLES, 32'd100_000_000, clk_d cycles the red light is shown per phase (> GRACE_CYCLES).
GRACE_CYCLES, 32'd25_000_000, cycles at the start of each red phase during which movement is ignored (player reaction time).
LIVES, 2'd3, lives granted at game start (1..3).

Ports:
clk_d  in  1  pixel/system clock
reset  in  1  asynchronous active-high reset
start_key  in  1  space key level from keyboard decoder
move  in  1  level; high while any arrow key is held
reached_finish  in  1  level; high while the player overlaps the finish zone
state  out  2  00=START, 01=GAME, 10=WON, 11=OVER
display_red  out  1  red light lit
display_green  out  1  green light lit
hearts  out  2  remaining lives, binary count 0..3
hit  out  1  one-cycle pulse when a life is lost

Behaviour:
- Reset is asynchronous and active-high; one clock, clk_d, with all state registered on its posedge.
- Reset values: state=START, display_red=0, display_green=0, hearts=0, hit=0, phase counter=0, start edge register=0.
- start_key is edge-detected internally. A press is start_key=1 while the previous sample was 0. A held key yields exactly one press.
- START: lights off, hearts=0.
  - On a press: next cycle state=GAME, hearts=LIVES, display_green=1, counter=0, red-hit flag cleared.
- GAME phase timer:
  - 32-bit counter increments every cycle.
  - In green: when counter==GREEN_CYCLES-1, the next cycle is red (display_red=1, display_green=0), counter=0, hit flag cleared.
  - In red: when counter==RED_CYCLES-1, the next cycle is green, counter=0.
  - Exactly one of display_red/display_green is high throughout GAME.
- Violation: in red with counter ≥ GRACE_CYCLES, move=1 and hit flag clear causes a loss on that edge.
  - hearts decrements by 1, hit pulses for 1 cycle, hit flag sets.
  - At most one life is lost per red phase, regardless of how long move is held.
  - Movement during green or during the grace window never costs a life.
- GAME exits, evaluated every cycle in priority order:
  1. If a violation takes hearts from 1 to 0, next state=OVER. This wins over a simultaneous reached_finish.
  2. Otherwise, reached_finish=1 gives next state=WON. A violation on the same cycle still decrements hearts and pulses hit.
- On leaving GAME: both lights are 0 and the counter freezes. hearts holds its final value in WON/OVER.
- WON / OVER: the state holds. A press returns the block to START and clears hearts to 0. A key still held from the GAME-entry press does not count as a press.
- Reset asserted mid-game returns the block to the reset values immediately (asynchronous), including in the middle of a hit pulse.
- hearts never underflows. Decrement is only possible when hearts≥1, which holds in GAME.

Test Plan:
(Parameters for all scenarios: GREEN_CYCLES=8, RED_CYCLES=6, GRACE_CYCLES=2, LIVES=3.)
- Reset then start: hold reset 3 cycles, release, one-cycle start_key -> state 00→01 one cycle after the press; hearts=3, display_green=1. Holding start_key 20 more cycles causes no further state change.
- Light timing: in GAME with move=0 -> green high for 8 cycles, red for 6, alternating; lights never both high or both low; hearts stays 3.
- Grace and single hit: move=1 for the whole red phase -> no loss during red cycles 0–1; at red cycle 2 hit pulses one cycle and hearts=2; no further loss in that phase. Moving in green -> no change.
- Game over: violate in three consecutive red phases -> hearts 3→2→1→0; state=11 the cycle after the third hit; lights off; a further press -> state=00, hearts=0.
- Win and tie-break: reached_finish=1 during green with hearts=2 -> state=10, hearts=2. Separately, finish on the same cycle as the hit that takes hearts 1→0 -> state=11.
- Async reset mid-game: assert reset between clock edges during red with hit high -> all outputs at reset values before the next edge.
